// File: rtl/clock_seq_ctrl.sv
// rtl/clock_seq_ctrl.sv - clock run/halt/adjust sequencer driving the seconds/minutes counters
// Synchronizes the user switches and buttons; strobes are registered and single-cycle.
module clock_seq_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1hz,
  input  logic tick_2hz,
  input  logic adj,
  input  logic sel,
  input  logic pause,
  input  logic clr,
  input  logic sec_max,
  output logic sec_inc,
  output logic min_inc,
  output logic clr_cnt,
  output logic blank_min,
  output logic blank_sec,
  output logic paused
);

  typedef enum logic [1:0] {RUN, HALT, ADJ_MIN, ADJ_SEC} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] adj_sync, sel_sync, pause_sync, clr_sync;
  logic pause_d, clr_d;
  logic blink_phase;

  logic adj_s, sel_s, pause_s, clr_s;
  logic pause_rise, clr_rise;
  logic paused_nxt, blink_nxt, entering_adj;
  logic sec_nxt, min_nxt;

  assign adj_s   = adj_sync[SYNC_STAGES-1];
  assign sel_s   = sel_sync[SYNC_STAGES-1];
  assign pause_s = pause_sync[SYNC_STAGES-1];
  assign clr_s   = clr_sync[SYNC_STAGES-1];

  assign pause_rise = pause_s & ~pause_d;
  assign clr_rise   = clr_s & ~clr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adj_sync   <= '0;
      sel_sync   <= '0;
      pause_sync <= '0;
      clr_sync   <= '0;
      pause_d    <= 1'b0;
      clr_d      <= 1'b0;
    end else begin
      adj_sync   <= {adj_sync[SYNC_STAGES-2:0], adj};
      sel_sync   <= {sel_sync[SYNC_STAGES-2:0], sel};
      pause_sync <= {pause_sync[SYNC_STAGES-2:0], pause};
      clr_sync   <= {clr_sync[SYNC_STAGES-2:0], clr};
      pause_d    <= pause_s;
      clr_d      <= clr_s;
    end
  end

  always_comb begin
    // Pause presses while adjusting are dropped, not deferred.
    paused_nxt = paused ^ (pause_rise & ~adj_s);
    if (adj_s) state_nxt = sel_s ? ADJ_SEC : ADJ_MIN;
    else       state_nxt = paused_nxt ? HALT : RUN;

    entering_adj = adj_s && (state_nxt != state);
    blink_nxt    = entering_adj ? 1'b0 : (blink_phase ^ tick_2hz);

    // A clear in the same cycle wins over any increment.
    sec_nxt = ~clr_rise & (((state == RUN) & tick_1hz) | ((state == ADJ_SEC) & tick_2hz));
    min_nxt = ~clr_rise & (((state == RUN) & tick_1hz & sec_max) | ((state == ADJ_MIN) & tick_2hz));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      paused      <= 1'b0;
      blink_phase <= 1'b0;
      sec_inc     <= 1'b0;
      min_inc     <= 1'b0;
      clr_cnt     <= 1'b0;
      blank_min   <= 1'b0;
      blank_sec   <= 1'b0;
    end else begin
      state       <= state_nxt;
      paused      <= paused_nxt;
      blink_phase <= blink_nxt;
      sec_inc     <= sec_nxt;
      min_inc     <= min_nxt;
      clr_cnt     <= clr_rise;
      blank_min   <= (state_nxt == ADJ_MIN) && blink_nxt;
      blank_sec   <= (state_nxt == ADJ_SEC) && blink_nxt;
    end
  end

endmodule

// File: tb/tb_clock_seq_ctrl.sv
// tb/tb_clock_seq_ctrl.sv - self-checking bench for clock_seq_ctrl
module tb_clock_seq_ctrl;

  logic clk = 1'b0;
  logic rst, tick_1hz, tick_2hz, adj, sel, pause, clr, sec_max;
  logic sec_inc, min_inc, clr_cnt, blank_min, blank_sec, paused;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  typedef struct packed {
    logic adj;
    logic sel;
    logic smax;
    logic t1;
    logic t2;
    logic es;
    logic em;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  clock_seq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .adj(adj), .sel(sel), .pause(pause), .clr(clr), .sec_max(sec_max),
    .sec_inc(sec_inc), .min_inc(min_inc), .clr_cnt(clr_cnt),
    .blank_min(blank_min), .blank_sec(blank_sec), .paused(paused)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Strobe scoreboard: one expectation per driven cycle, checked just after the edge.
  always @(posedge clk) begin
    logic [1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("strobe", {6'b0, sec_inc, min_inc}, {6'b0, e});
    end
  end

  task automatic cyc(input logic t1, input logic t2, input logic es, input logic em);
    @(negedge clk);
    tick_1hz = t1;
    tick_2hz = t2;
    exp_q.push_back({es, em});
    @(posedge clk);
    #2;
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic eb;
    //           adj sel smax t1 t2 es em
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0;
    adj = 1'b0; sel = 1'b0; pause = 1'b0; clr = 1'b0; sec_max = 1'b0;
    #2 rst = 1'b0;
    #4;
    chk("reset_outputs", {2'b0, sec_inc, min_inc, clr_cnt, blank_min, blank_sec, paused}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Tick on cycle 10 after release, strobe on cycle 11 only.
    idle(9);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    for (int i = 0; i < 12; i++) begin
      adj = tbl[i].adj;
      sel = tbl[i].sel;
      sec_max = tbl[i].smax;
      idle(4);
      cyc(tbl[i].t1, tbl[i].t2, tbl[i].es, tbl[i].em);
      chk($sformatf("vec%0d", i), {6'b0, sec_inc, min_inc}, {6'b0, tbl[i].es, tbl[i].em});
    end

    // Pause press held 50 cycles.
    adj = 1'b0; sel = 1'b0; sec_max = 1'b0;
    idle(4);
    pause = 1'b1;
    idle(2);
    chk("pause_wait", {7'b0, paused}, 8'h00);
    idle(1);
    chk("pause_on", {7'b0, paused}, 8'h01);
    for (int i = 0; i < 47; i++) begin
      if (i % 15 == 7) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      else             cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("pause_held", {7'b0, paused}, 8'h01);
    pause = 1'b0;
    idle(4);
    pause = 1'b1;
    idle(3);
    chk("pause_off", {7'b0, paused}, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    pause = 1'b0;
    idle(3);

    // Adjust seconds: no carry, blink alternates, pause ignored.
    adj = 1'b1; sel = 1'b1; sec_max = 1'b1;
    idle(4);
    chk("adj_entry_blank", {6'b0, blank_min, blank_sec}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      eb = (k % 2 == 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("blank_sec%0d", k), {7'b0, blank_sec}, {7'b0, eb});
      chk($sformatf("blank_min%0d", k), {7'b0, blank_min}, 8'h00);
      idle(2);
    end
    pause = 1'b1;
    idle(5);
    chk("pause_in_adj", {7'b0, paused}, 8'h00);
    pause = 1'b0;
    idle(3);

    // Clear edge coincident with a 1 Hz tick in RUN.
    adj = 1'b0; sel = 1'b0; sec_max = 1'b0;
    idle(4);
    clr = 1'b1;
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_cnt_on", {7'b0, clr_cnt}, 8'h01);
    chk("clr_paused", {7'b0, paused}, 8'h00);
    idle(1);
    chk("clr_cnt_off", {7'b0, clr_cnt}, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_held", {7'b0, clr_cnt}, 8'h00);
    clr = 1'b0;
    idle(3);

    // Reset while blinking in minute adjust.
    adj = 1'b1; sel = 1'b0;
    idle(4);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("blank_min_on", {7'b0, blank_min}, 8'h01);
    rst = 1'b0;
    #1;
    chk("reset_mid_adj", {2'b0, sec_inc, min_inc, clr_cnt, blank_min, blank_sec, paused}, 8'h00);
    adj = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    idle(6);
    chk("post_reset_blank", {6'b0, blank_min, blank_sec}, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_seq_ctrl.md
CLOCK_SEQ_CTRL -- requirements
Module: clock_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, number of synchronizer flops on each user switch/button input (legal 2..4).
REQ-002 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port tick_1hz  input  1  single-cycle pulse, clk-synchronous, once per second.
REQ-005 The block SHALL have port tick_2hz  input  1  single-cycle pulse, clk-synchronous, twice per second.
REQ-006 The block SHALL have port adj  input  1  asynchronous level switch, 1 = adjust mode.
REQ-007 The block SHALL have port sel  input  1  asynchronous level switch, 0 = adjust minutes, 1 = adjust seconds.
REQ-008 The block SHALL have port pause  input  1  asynchronous debounced button level, rising edge toggles pause.
REQ-009 The block SHALL have port clr  input  1  asynchronous debounced button level, rising edge clears the time.
REQ-010 The block SHALL have port sec_max  input  1  from datapath, high when seconds counter == 59.
REQ-011 The block SHALL have port sec_inc  output  1  registered single-cycle seconds-increment strobe.
REQ-012 The block SHALL have port min_inc  output  1  registered single-cycle minutes-increment strobe.
REQ-013 The block SHALL have port clr_cnt  output  1  registered single-cycle clear strobe to both counters.
REQ-014 The block SHALL have port blank_min / blank_sec  output  1 each  registered digit-group blanking for adjust blink.
REQ-015 The block SHALL have port paused  output  1  registered pause flag.

Function
REQ-016 adj, sel, pause, clr SHALL each pass through SYNC_STAGES flops; edge detection SHALL use one further flop on synchronized pause/clr.
REQ-017 FSM states SHALL be RUN, HALT, ADJ_MIN, ADJ_SEC; encoding free.
REQ-018 Transitions: any state -> ADJ_MIN if adj_s=1,sel_s=0; -> ADJ_SEC if adj_s=1,sel_s=1; adj_s=0 -> HALT if paused=1 else RUN.
REQ-019 Pause rising edge SHALL toggle paused only when adj_s=0; edges during ADJ_* SHALL be ignored; paused SHALL persist through ADJ_*.
REQ-020 RUN: sec_inc SHALL assert one cycle after tick_1hz; min_inc SHALL assert in the same cycle as sec_inc iff sec_max was 1 when tick_1hz sampled.
REQ-021 HALT: sec_inc, min_inc SHALL stay 0.
REQ-022 ADJ_MIN: min_inc SHALL assert one cycle after tick_2hz; sec_inc 0. ADJ_SEC: sec_inc one cycle after tick_2hz; min_inc 0 regardless of sec_max (no carry).
REQ-023 tick_1hz SHALL be ignored in ADJ_*; tick_2hz SHALL be ignored in RUN/HALT for increments.
REQ-024 blink_phase register SHALL toggle on each tick_2hz and SHALL clear to 0 on entry to any ADJ_* state.
REQ-025 blank_min SHALL equal (state==ADJ_MIN && blink_phase); blank_sec SHALL equal (state==ADJ_SEC && blink_phase); both 0 otherwise, registered.
REQ-026 clr rising edge SHALL produce clr_cnt for exactly one cycle in any state; paused and state SHALL be unchanged.
REQ-027 If clr edge and an increment-qualifying tick occur in the same cycle, clr_cnt SHALL assert and sec_inc/min_inc SHALL stay 0 that cycle.
REQ-028 Held pause/clr levels SHALL produce exactly one action per rising edge.

Reset
REQ-029 On rst=0 all flops SHALL clear asynchronously: state=RUN, paused=0, blink_phase=0, synchronizers=0, sec_inc=min_inc=clr_cnt=blank_min=blank_sec=0.
REQ-030 Reset assertion mid-strobe SHALL drop the strobe immediately; after release, first increment SHALL require a fresh tick.
REQ-031 Reset release SHALL be treated as synchronous to clk by the system; the block need not resynchronize it.

Verification
REQ-032 Run: release rst, adj=sel=pause=0, sec_max=0, tick_1hz at cycle 10 -> sec_inc=1 at cycle 11 only, min_inc=0.
REQ-033 Carry: sec_max=1, tick_1hz -> sec_inc and min_inc both 1 in the same single cycle.
REQ-034 Pause: pause 0->1 held 50 cycles -> paused=1 after SYNC_STAGES+1 cycles, three tick_1hz -> no strobes; second press -> paused=0, next tick strobes.
REQ-035 Adjust: adj=1,sel=1, sec_max=1, four tick_2hz -> four sec_inc, zero min_inc; blank_sec alternates 1,0,1,0; blank_min=0; pause press ignored.
REQ-036 Clear collision: clr edge and tick_1hz coincident in RUN -> clr_cnt=1 one cycle, sec_inc=0, paused unchanged.
REQ-037 Reset mid-adjust: in ADJ_MIN with blank_min=1, pull rst=0 -> all outputs 0 immediately; release with adj=0 -> state RUN.
